// File: rtl/udsp_frame_sequencer.sv
// Frame sequencer for the audio DSP core: starts one program pass per
// sample tick, drains the pipeline and arbitrates data-memory writes.
module udsp_frame_sequencer #(
  parameter int IAW   = 9,
  parameter int DAW   = 10,
  parameter int DWW   = 36,
  parameter int DRAIN = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           sample_tick,
  input  logic [IAW:0]   prog_len,
  output logic           dsp_start,
  output logic           busy,
  output logic           frame_done,
  output logic           overrun,
  input  logic           overrun_clr,
  output logic [15:0]    frame_count,
  input  logic [DAW-1:0] dsp_addr_w,
  input  logic [DWW-1:0] dsp_data_w,
  input  logic           dsp_wren,
  input  logic           host_req,
  input  logic [DAW-1:0] host_addr,
  input  logic [DWW-1:0] host_data,
  output logic           host_ack,
  output logic [DAW-1:0] mem_addr,
  output logic [DWW-1:0] mem_data,
  output logic           mem_wren
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [IAW:0]   RUN_ONE   = (IAW+1)'(1);
  localparam logic [DCW-1:0] DRAIN_END = DCW'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [IAW:0]   run_cnt_q, run_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           pending_q, pending_d;
  logic           overrun_q, overrun_d;
  logic [15:0]    frame_count_q, frame_count_d;

  logic tick_en;
  logic len_nz;
  logic start_go;
  logic last_drain;
  logic host_grant;
  logic ov_set;

  assign tick_en    = sample_tick & enable;
  assign len_nz     = |prog_len;
  assign start_go   = (state_q == S_IDLE) & (tick_en | pending_q) & len_nz;
  assign last_drain = (drain_cnt_q == DRAIN_END);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      run_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state, counters, pending tick and overrun tracking
  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;
    ov_set        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d   = S_START;
          // a tick landing with a pending start becomes the next pending one
          pending_d = pending_q & tick_en;
        end
      end
      S_START: begin
        run_cnt_d   = prog_len;
        drain_cnt_d = '0;
        state_d     = len_nz ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q - RUN_ONE;
        if (run_cnt_q == RUN_ONE) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCW'(1);
        if (last_drain) begin
          state_d       = S_IDLE;
          drain_cnt_d   = '0;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && tick_en) begin
      if (pending_q) ov_set = 1'b1;
      else           pending_d = 1'b1;
    end
    overrun_d = ov_set | (overrun_q & ~overrun_clr);
  end

  // Moore status outputs and write-port arbitration
  always_comb begin
    host_grant  = ~reset & (state_q == S_IDLE) & host_req & ~start_go;
    dsp_start   = ~reset & (state_q == S_START);
    busy        = ~reset & (state_q != S_IDLE);
    frame_done  = ~reset & (state_q == S_DRAIN) & last_drain;
    overrun     = overrun_q;
    frame_count = frame_count_q;
    host_ack    = host_grant;
    mem_addr    = host_grant ? host_addr : dsp_addr_w;
    mem_data    = host_grant ? host_data : dsp_data_w;
    mem_wren    = host_grant | (~reset & (state_q != S_IDLE) & dsp_wren);
  end

endmodule

// File: tb/tb_udsp_frame_sequencer.sv
// Bench for udsp_frame_sequencer: directed latency/arbitration sequences,
// an IDLE arbitration table and a randomized run against a frame-time model.
module tb_udsp_frame_sequencer;

  localparam int IAW   = 9;
  localparam int DAW   = 10;
  localparam int DWW   = 36;
  localparam int DRAIN = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           sample_tick;
  logic [IAW:0]   prog_len;
  logic           dsp_start;
  logic           busy;
  logic           frame_done;
  logic           overrun;
  logic           overrun_clr;
  logic [15:0]    frame_count;
  logic [DAW-1:0] dsp_addr_w;
  logic [DWW-1:0] dsp_data_w;
  logic           dsp_wren;
  logic           host_req;
  logic [DAW-1:0] host_addr;
  logic [DWW-1:0] host_data;
  logic           host_ack;
  logic [DAW-1:0] mem_addr;
  logic [DWW-1:0] mem_data;
  logic           mem_wren;

  int n_tests = 0;
  int n_fail  = 0;

  udsp_frame_sequencer #(
    .IAW(IAW), .DAW(DAW), .DWW(DWW), .DRAIN(DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_tick(sample_tick), .prog_len(prog_len),
    .dsp_start(dsp_start), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .frame_count(frame_count),
    .dsp_addr_w(dsp_addr_w), .dsp_data_w(dsp_data_w),
    .dsp_wren(dsp_wren),
    .host_req(host_req), .host_addr(host_addr),
    .host_data(host_data), .host_ack(host_ack),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hreq;
    logic       tick;
    logic       en;
    logic [9:0] plen;
    logic       dwren;
    logic       exp_ack;
    logic       exp_wren;
    logic       exp_start;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic quiet_inputs();
    enable      = 1'b1;
    sample_tick = 1'b0;
    prog_len    = 10'd8;
    overrun_clr = 1'b0;
    dsp_addr_w  = '0;
    dsp_data_w  = '0;
    dsp_wren    = 1'b0;
    host_req    = 1'b0;
    host_addr   = '0;
    host_data   = '0;
  endtask

  // returns at the negedge of the first cycle after reset
  task automatic do_reset();
    @(negedge clk);
    quiet_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_ticks(input logic [31:0] tmask,
                           output logic [31:0] sv,
                           output logic [31:0] bv,
                           output logic [31:0] fv,
                           output logic ov_end,
                           output logic [15:0] fc_end);
    sv = '0; bv = '0; fv = '0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      sample_tick = tmask[k];
      #1;
      sv[k] = dsp_start;
      bv[k] = busy;
      fv[k] = frame_done;
    end
    sample_tick = 1'b0;
    ov_end = overrun;
    fc_end = frame_count;
  endtask

  logic [31:0] sv, bv, fv;
  logic        ov_e;
  logic [15:0] fc_e;
  int          first_ack;
  logic [DAW-1:0] ack_addr;
  logic [DWW-1:0] ack_data;
  logic        any_act;

  // reference model state (frame start cycle and length)
  int          m_fs, m_fl, m_cnt;
  logic        m_pend, m_ov;
  logic        e_busy, e_start, e_done, e_ack, e_wren, m_go, m_te;

  initial begin
    reset = 1'b1;
    quiet_inputs();

    tbl[0] = '{1, 0, 1, 10'd8, 0, 1, 1, 0};
    tbl[1] = '{1, 1, 1, 10'd8, 0, 0, 0, 1};
    tbl[2] = '{1, 1, 0, 10'd8, 0, 1, 1, 0};
    tbl[3] = '{1, 1, 1, 10'd0, 0, 1, 1, 0};
    tbl[4] = '{0, 0, 1, 10'd8, 1, 0, 0, 0};
    tbl[5] = '{0, 1, 1, 10'd8, 1, 0, 0, 1};

    // reset state
    do_reset();
    #1;
    chk("reset_outs", {dsp_start, busy, frame_done, host_ack, mem_wren}, 5'b0);
    chk("reset_ovr", overrun, 1'b0);
    chk("reset_cnt", frame_count, 16'd0);

    // single frame latency, prog_len=8
    do_reset();
    run_ticks(32'h1, sv, bv, fv, ov_e, fc_e);
    chk("lat_start", sv, 32'h0000_0002);
    chk("lat_busy", bv, 32'h0000_1FFE);
    chk("lat_done", fv, 32'h0000_1000);
    chk("lat_count", fc_e, 16'd1);

    // tick while busy becomes pending
    do_reset();
    run_ticks(32'h21, sv, bv, fv, ov_e, fc_e);
    chk("pend_start", sv, 32'h0000_4002);
    chk("pend_busy", bv, 32'h03FF_DFFE);
    chk("pend_done", fv, 32'h0200_1000);
    chk("pend_ovr", ov_e, 1'b0);
    chk("pend_count", fc_e, 16'd2);

    // third tick overflows pending
    do_reset();
    run_ticks(32'h61, sv, bv, fv, ov_e, fc_e);
    chk("ovr_start", sv, 32'h0000_4002);
    chk("ovr_flag", ov_e, 1'b1);
    chk("ovr_count", fc_e, 16'd2);
    @(negedge clk);
    #1;
    chk("ovr_sticky", overrun, 1'b1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    #1;
    chk("ovr_clr", overrun, 1'b0);

    // host vs tick tie, host served after the frame
    do_reset();
    host_req    = 1'b1;
    host_addr   = 10'h123;
    host_data   = 36'hABCDE;
    sample_tick = 1'b1;
    #1;
    chk("tie_ack", {host_ack, mem_wren}, 2'b00);
    first_ack = -1;
    ack_addr  = '0;
    ack_data  = '0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      #1;
      if (k == 1) chk("tie_start", dsp_start, 1'b1);
      if (host_ack && first_ack < 0) begin
        first_ack = k;
        ack_addr  = mem_addr;
        ack_data  = mem_data;
      end
    end
    chk("tie_ack_cycle", first_ack, 13);
    chk("tie_addr", ack_addr, 10'h123);
    chk("tie_data", ack_data, 36'hABCDE);
    host_req = 1'b0;

    // DSP owns the port during RUN
    do_reset();
    sample_tick = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
    dsp_wren   = 1'b1;
    dsp_addr_w = 10'h040;
    dsp_data_w = 36'h5_5555_5555;
    host_req   = 1'b1;
    host_addr  = 10'h3FF;
    host_data  = 36'hF_0000_0001;
    #1;
    chk("run_addr", mem_addr, 10'h040);
    chk("run_data", mem_data, 36'h5_5555_5555);
    chk("run_wren_ack", {mem_wren, host_ack}, 2'b10);

    // prog_len=0 ignores ticks
    do_reset();
    prog_len = 10'd0;
    run_ticks(32'h1, sv, bv, fv, ov_e, fc_e);
    chk("zero_start", sv, 32'h0);
    chk("zero_busy", bv, 32'h0);
    chk("zero_done", fv, 32'h0);
    prog_len = 10'd8;
    @(negedge clk);
    #1;
    chk("zero_no_pend", busy, 1'b0);

    // reset at RUN cycle 3 aborts the frame
    do_reset();
    sample_tick = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
    reset    = 1'b1;
    host_req = 1'b1;
    dsp_wren = 1'b1;
    #1;
    chk("abort_outs", {dsp_start, busy, frame_done, host_ack, mem_wren}, 5'b0);
    @(negedge clk);
    reset    = 1'b0;
    host_req = 1'b0;
    dsp_wren = 1'b0;
    any_act  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      any_act = any_act | busy | frame_done | dsp_start;
    end
    chk("abort_quiet", any_act, 1'b0);
    chk("abort_count", frame_count, 16'd0);

    // frame_count wrap from 0xFFFF
    do_reset();
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    prog_len = 10'd1;
    run_ticks(32'h1, sv, bv, fv, ov_e, fc_e);
    chk("wrap_done", fv, 32'h0000_0020);
    chk("wrap_count", fc_e, 16'h0000);

    // IDLE arbitration table
    foreach (tbl[i]) begin
      do_reset();
      host_req    = tbl[i].hreq;
      sample_tick = tbl[i].tick;
      enable      = tbl[i].en;
      prog_len    = tbl[i].plen;
      dsp_wren    = tbl[i].dwren;
      host_addr   = DAW'($urandom);
      host_data   = DWW'({$urandom, $urandom});
      dsp_addr_w  = ~host_addr;
      dsp_data_w  = ~host_data;
      #1;
      chk($sformatf("tbl%0d_ack", i), host_ack, tbl[i].exp_ack);
      chk($sformatf("tbl%0d_wren", i), mem_wren, tbl[i].exp_wren);
      if (tbl[i].exp_wren)
        chk($sformatf("tbl%0d_addr", i), {mem_addr, mem_data},
            {host_addr, host_data});
      @(negedge clk);
      sample_tick = 1'b0;
      host_req    = 1'b0;
      dsp_wren    = 1'b0;
      #1;
      chk($sformatf("tbl%0d_start", i), dsp_start, tbl[i].exp_start);
    end

    // randomized run against the frame-time model
    do_reset();
    prog_len = 10'd3;
    m_fs   = -1000;
    m_fl   = 0;
    m_cnt  = 0;
    m_pend = 1'b0;
    m_ov   = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      sample_tick = ($urandom_range(0, 7) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) prog_len = 10'($urandom_range(0, 5));
      overrun_clr = ($urandom_range(0, 19) == 0);
      host_req    = $urandom_range(0, 1) == 1;
      dsp_wren    = $urandom_range(0, 1) == 1;
      host_addr   = DAW'($urandom);
      host_data   = DWW'({$urandom, $urandom});
      dsp_addr_w  = DAW'($urandom);
      dsp_data_w  = DWW'({$urandom, $urandom});
      if (c == m_fs) m_fl = int'(prog_len);
      e_busy  = (c >= m_fs) && (c <= m_fs + m_fl + DRAIN);
      e_start = (c == m_fs);
      e_done  = (c == m_fs + m_fl + DRAIN);
      m_te    = sample_tick & enable;
      m_go    = !e_busy && (m_te || m_pend) && (prog_len != 0);
      e_ack   = !e_busy && host_req && !m_go;
      e_wren  = e_busy ? dsp_wren : e_ack;
      #1;
      chk($sformatf("rnd%0d", c),
          {dsp_start, busy, frame_done, overrun, frame_count,
           host_ack, mem_wren},
          {e_start, e_busy, e_done, m_ov, 16'(m_cnt), e_ack, e_wren});
      if (e_wren)
        chk($sformatf("rnd%0d_port", c), {mem_addr, mem_data},
            e_ack ? {host_addr, host_data} : {dsp_addr_w, dsp_data_w});
      if (e_done) m_cnt++;
      if (m_go) begin
        m_fs   = c + 1;
        m_fl   = 0;
        m_pend = m_pend && m_te;
        m_ov   = m_ov && !overrun_clr;
      end else if (e_busy && m_te) begin
        if (m_pend) m_ov = 1'b1;
        else begin
          m_pend = 1'b1;
          m_ov   = m_ov && !overrun_clr;
        end
      end else begin
        m_ov = m_ov && !overrun_clr;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
